// File: rtl/fast_square_pkg.sv
// Shared types and defaults for the fast-square sweep sequencer.
// State encoding is visible on state_out for debug.
package fast_square_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RXRST    = 3'd1,
    S_SETTLE   = 3'd2,
    S_RECORD   = 3'd3,
    S_NEXT     = 3'd4,
    S_STEP     = 3'd5,
    S_WAITSYNC = 3'd6
  } fs_state_e;

  localparam int DEF_RECORD_TICKS     = 35000;
  localparam int DEF_SETTLE_TICKS     = 256;
  localparam int DEF_STEP_PULSE_TICKS = 4;

  localparam logic [6:0] DEF_ADDR_CFG = 7'd66;

endpackage

// File: rtl/fast_square_sweep_ctrl_if.sv
// Settings bus into the sweep sequencer.
// The host drives it, the sequencer listens.
interface fast_square_sweep_ctrl_if;

  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;

  modport master (
    output serial_strobe,
    output serial_addr,
    output serial_data
  );

  modport slave (
    input serial_strobe,
    input serial_addr,
    input serial_data
  );

endinterface

// File: rtl/fs_tick_timer.sv
// Loadable down-counter with zero flag; a load of 0 is
// treated as 1 so every window lasts at least one cycle.
module fs_tick_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] ticks,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (ticks == '0) ? '0 : ticks - CNT_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/setting_reg.sv
// Settings-bus register: latches the data word on a
// strobed write to its own address.
module setting_reg #(
  parameter logic [6:0]       MY_ADDR  = 7'd0,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             strobe,
  input  logic [6:0]       addr,
  input  logic [31:0]      in,
  output logic [WIDTH-1:0] out,
  output logic             changed
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             changed_q, changed_d;
  logic             hit;

  assign hit = strobe && (addr == MY_ADDR);

  always_comb begin
    out_d     = out_q;
    changed_d = hit;
    if (hit) out_d = in[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q     <= AT_RESET;
      changed_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      changed_q <= changed_d;
    end
  end

  assign out     = out_q;
  assign changed = changed_q;

endmodule

// File: rtl/fast_square_sweep_ctrl.sv
// Frequency sweep sequencer: step pulse, settle, record gate per step.
// FAST_SQUARE_SERIAL_CFG_EN makes settle/record ticks serial-programmable.
import fast_square_pkg::*;

module fast_square_sweep_ctrl #(
  parameter int         NUM_FREQ_STEPS   = 32,
  parameter int         STEP_W           = 8,
  parameter int         NUM_CHAN         = 2,
  parameter int         CNT_W            = 16,
  parameter int         RECORD_TICKS     = DEF_RECORD_TICKS,
  parameter int         SETTLE_TICKS     = DEF_SETTLE_TICKS,
  parameter int         STEP_PULSE_TICKS = DEF_STEP_PULSE_TICKS,
  parameter logic [6:0] ADDR_CFG         = DEF_ADDR_CFG
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 freq_step_reset_in,
  input  logic [NUM_CHAN-1:0]  chan_mask,
  fast_square_sweep_ctrl_if.slave cfg,
  output logic                 freq_step_out,
  output logic [STEP_W-1:0]    freq_step_idx,
  output logic                 rx_reset,
  output logic                 rx_next,
  output logic [NUM_CHAN-1:0]  rx_record,
  output logic                 sweep_done,
  output logic [2:0]           state_out
);

  localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_FREQ_STEPS - 1);

  logic [CNT_W-1:0] record_ticks, settle_ticks;

`ifdef FAST_SQUARE_SERIAL_CFG_EN
  logic [31:0] cfg_word;
  logic        cfg_changed_unused;

  setting_reg #(
    .MY_ADDR  (ADDR_CFG),
    .WIDTH    (32),
    .AT_RESET ({16'(SETTLE_TICKS), 16'(RECORD_TICKS)})
  ) u_cfg (
    .clock   (clock),
    .reset   (reset),
    .strobe  (cfg.serial_strobe),
    .addr    (cfg.serial_addr),
    .in      (cfg.serial_data),
    .out     (cfg_word),
    .changed (cfg_changed_unused)
  );

  assign record_ticks = CNT_W'(cfg_word[15:0]);
  assign settle_ticks = CNT_W'(cfg_word[31:16]);
`else
  logic unused_cfg;

  assign unused_cfg = ^{cfg.serial_strobe, cfg.serial_addr,
                        cfg.serial_data, ADDR_CFG};
  assign record_ticks = CNT_W'(RECORD_TICKS);
  assign settle_ticks = CNT_W'(SETTLE_TICKS);
`endif

  fs_state_e           state_q, state_d;
  logic                step_out_q, step_out_d;
  logic [STEP_W-1:0]   idx_q, idx_d;
  logic                rx_reset_q, rx_reset_d;
  logic                rx_next_q, rx_next_d;
  logic [NUM_CHAN-1:0] rec_q, rec_d;
  logic                done_q, done_d;

  logic             entering;
  logic             tmr_zero;
  logic [CNT_W-1:0] load_ticks;

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (freq_step_reset_in && state_q != S_IDLE) begin
      state_d = S_RXRST;
    end else begin
      unique case (state_q)
        S_IDLE:     state_d = S_RXRST;
        S_RXRST:    state_d = S_SETTLE;
        S_SETTLE:   if (tmr_zero) state_d = S_RECORD;
        S_RECORD:   if (tmr_zero) state_d = S_NEXT;
        S_NEXT:     state_d = (idx_q == LAST_IDX) ? S_WAITSYNC : S_STEP;
        S_STEP:     if (tmr_zero) state_d = S_SETTLE;
        S_WAITSYNC: state_d = S_WAITSYNC;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  assign entering = (state_d != state_q);

  // Tick values are captured here, on window entry.
  always_comb begin
    load_ticks = CNT_W'(STEP_PULSE_TICKS);
    unique case (1'b1)
      state_d == S_SETTLE: load_ticks = settle_ticks;
      state_d == S_RECORD: load_ticks = record_ticks;
      default:             load_ticks = CNT_W'(STEP_PULSE_TICKS);
    endcase
  end

  fs_tick_timer #(
    .CNT_W (CNT_W)
  ) u_tmr (
    .clk   (clock),
    .rst   (reset),
    .load  (entering),
    .ticks (load_ticks),
    .zero  (tmr_zero)
  );

  always_comb begin
    rx_reset_d = (state_d == S_RXRST);
    rx_next_d  = (state_d == S_NEXT);
    done_d     = (state_d == S_NEXT) && (idx_q == LAST_IDX);
    step_out_d = (state_d == S_STEP);
    rec_d      = '0;
    if (state_d == S_RECORD) rec_d = entering ? chan_mask : rec_q;
    idx_d = idx_q;
    if (state_d == S_IDLE || state_d == S_RXRST) begin
      idx_d = '0;
    end else if (state_d == S_STEP && entering) begin
      idx_d = idx_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_out_q <= 1'b0;
      idx_q      <= '0;
      rx_reset_q <= 1'b0;
      rx_next_q  <= 1'b0;
      rec_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_out_q <= step_out_d;
      idx_q      <= idx_d;
      rx_reset_q <= rx_reset_d;
      rx_next_q  <= rx_next_d;
      rec_q      <= rec_d;
      done_q     <= done_d;
    end
  end

  assign freq_step_out = step_out_q;
  assign freq_step_idx = idx_q;
  assign rx_reset      = rx_reset_q;
  assign rx_next       = rx_next_q;
  assign rx_record     = rec_q;
  assign sweep_done    = done_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Directed bench for the sweep sequencer with a pulse scoreboard
// for rx_next / freq_step_out events.
module tb_fast_square_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       fsr;
  logic [1:0] chan_mask;
  logic       fso;
  logic [7:0] idx;
  logic       rx_reset;
  logic       rx_next;
  logic [1:0] rx_record;
  logic       done;
  logic [2:0] state_out;

  fast_square_sweep_ctrl_if cfg_if ();

  fast_square_sweep_ctrl #(
    .NUM_FREQ_STEPS   (4),
    .STEP_W           (8),
    .NUM_CHAN         (2),
    .CNT_W            (16),
    .RECORD_TICKS     (10),
    .SETTLE_TICKS     (3),
    .STEP_PULSE_TICKS (2),
    .ADDR_CFG         (7'd66)
  ) dut (
    .clock              (clk),
    .reset              (reset),
    .enable             (enable),
    .freq_step_reset_in (fsr),
    .chan_mask          (chan_mask),
    .cfg                (cfg_if.slave),
    .freq_step_out      (fso),
    .freq_step_idx      (idx),
    .rx_reset           (rx_reset),
    .rx_next            (rx_next),
    .rx_record          (rx_record),
    .sweep_done         (done),
    .state_out          (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int idx;
    int dn;
  } ev_t;

  ev_t  nxt_q[$];
  ev_t  stp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rel = 0;
  logic fso_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_next(input int c, input int i, input int d);
    ev_t e;
    e.cyc = c; e.idx = i; e.dn = d;
    nxt_q.push_back(e);
  endtask

  task automatic push_step(input int c, input int i);
    ev_t e;
    e.cyc = c; e.idx = i; e.dn = 0;
    stp_q.push_back(e);
  endtask

  task automatic tick();
    ev_t e;
    @(negedge clk);
    rel++;
    if (rx_next === 1'b1) begin
      chk("next_no_overlap", 32'(rx_record), 0);
      chk("next_expected", 32'(nxt_q.size() != 0), 1);
      if (nxt_q.size() != 0) begin
        e = nxt_q.pop_front();
        chk("next_cycle", rel, e.cyc);
        chk("next_idx", 32'(idx), e.idx);
        chk("next_done", 32'(done), e.dn);
      end
    end
    if (done === 1'b1) chk("done_with_next", 32'(rx_next), 1);
    if (fso === 1'b1 && fso_prev !== 1'b1) begin
      chk("step_expected", 32'(stp_q.size() != 0), 1);
      if (stp_q.size() != 0) begin
        e = stp_q.pop_front();
        chk("step_cycle", rel, e.cyc);
        chk("step_idx", 32'(idx), e.idx);
      end
    end
    fso_prev = fso;
  endtask

  task automatic go(input int n);
    while (rel < n) tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(state_out), 0);
    chk({tag, "_outs"},
        32'({fso, idx, rx_reset, rx_next, rx_record, done}), 0);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    fsr       = 1'b0;
    chan_mask = 2'b11;
    cfg_if.serial_strobe = 1'b0;
    cfg_if.serial_addr   = 7'd0;
    cfg_if.serial_data   = 32'd0;
    repeat (3) tick();
    chk_idle("reset");
    reset = 1'b0;
    tick();
    chk_idle("post_reset");

    // Full sweep from enable
    rel = 0;
    enable = 1'b1;
    for (int s = 0; s < 4; s++) push_next(15 + 16 * s, s, s == 3 ? 1 : 0);
    for (int s = 1; s < 4; s++) push_step(16 * s, s);
    go(1);
    chk("start_rx_reset", 32'(rx_reset), 1);
    chk("start_idx", 32'(idx), 0);
    chk("start_state", 32'(state_out), 1);
    go(2);
    chk("settle_state", 32'(state_out), 2);
    go(4);
    chk("settle_no_rec", 32'(rx_record), 0);
    go(5);
    chk("rec_first", 32'(rx_record), 2'b11);
    go(14);
    chk("rec_last", 32'(rx_record), 2'b11);
    go(15);
    chk("rec_drop_at_next", 32'(rx_record), 0);
    go(17);
    chk("step_hold", 32'({fso, idx}), {1'b1, 8'd1});
    go(18);
    chk("step_end", 32'(fso), 0);
    go(70);
    chk("waitsync_state", 32'(state_out), 6);
    chk("waitsync_idx", 32'(idx), 3);
    chk("sweep_next_left", nxt_q.size(), 0);
    chk("sweep_step_left", stp_q.size(), 0);

    // Resync from WAITSYNC, then abort during step-2 record
    rel = 0;
    fsr = 1'b1;
    push_next(15, 0, 0);
    push_step(16, 1);
    push_next(31, 1, 0);
    push_step(32, 2);
    tick();
    fsr = 1'b0;
    chk("resync_rx_reset", 32'(rx_reset), 1);
    chk("resync_idx", 32'(idx), 0);
    go(40);
    chk("abort_pre_rec", 32'({idx, rx_record}), {8'd2, 2'b11});
    fsr = 1'b1;
    tick();
    fsr = 1'b0;
    chk("abort_rec", 32'(rx_record), 0);
    chk("abort_rx_reset", 32'(rx_reset), 1);
    chk("abort_idx", 32'(idx), 0);
    chk("abort_state", 32'(state_out), 1);

    // Disable beats a simultaneous resync mid-settle
    rel = 1;
    go(3);
    enable = 1'b0;
    fsr    = 1'b1;
    tick();
    fsr = 1'b0;
    chk_idle("disable");
    tick();
    chk_idle("disable_hold");

    // Channel mask sampled at record entry
    rel = 0;
    enable    = 1'b1;
    chan_mask = 2'b01;
    push_next(15, 0, 0);
    push_step(16, 1);
    go(5);
    chk("mask_rec", 32'(rx_record), 2'b01);
    go(8);
    chan_mask = 2'b10;
    go(14);
    chk("mask_held", 32'(rx_record), 2'b01);
    go(21);
    chk("mask_next_win", 32'(rx_record), 2'b10);
    enable = 1'b0;
    tick();
    chk_idle("mask_off");
    chk("mask_next_left", nxt_q.size(), 0);
    chk("mask_step_left", stp_q.size(), 0);

`ifdef FAST_SQUARE_SERIAL_CFG_EN
    // Serial write mid-record affects the following windows only
    rel = 0;
    enable    = 1'b1;
    chan_mask = 2'b11;
    push_next(15, 0, 0);
    push_step(16, 1);
    push_next(43, 1, 0);
    push_step(44, 2);
    push_next(48, 2, 0);
    go(7);
    cfg_if.serial_strobe = 1'b1;
    cfg_if.serial_addr   = 7'd66;
    cfg_if.serial_data   = 32'h0005_0014;
    tick();
    cfg_if.serial_strobe = 1'b0;
    go(14);
    chk("cfg_cur_win", 32'(rx_record), 2'b11);
    go(22);
    chk("cfg_settle5", 32'({state_out, rx_record}), {3'd2, 2'b00});
    go(23);
    chk("cfg_rec_start", 32'(rx_record), 2'b11);
    go(42);
    chk("cfg_rec20", 32'(rx_record), 2'b11);
    go(44);
    cfg_if.serial_strobe = 1'b1;
    cfg_if.serial_data   = 32'h0;
    tick();
    cfg_if.serial_strobe = 1'b0;
    go(46);
    chk("cfg_zero_settle", 32'(state_out), 2);
    go(47);
    chk("cfg_zero_rec", 32'({state_out, rx_record}), {3'd3, 2'b11});
    go(48);
    chk("cfg_zero_next", 32'(rx_next), 1);
    enable = 1'b0;
    tick();
    chk_idle("cfg_off");
    chk("cfg_next_left", nxt_q.size(), 0);
    chk("cfg_step_left", stp_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fast_square_sweep_ctrl.md
# fast_square_sweep_ctrl

Parametrised sweep sequencer for the fast-square receiver path. It runs a programmable number of frequency steps, pulsing the external synthesizer step line on a daughterboard I/O pin. At each step it waits a settle interval and then gates a per-channel record window to the `fast_square_rx` instances. It sits in `usrp_std` on `clk64`, between the debounced sync input and the RX capture blocks, and supports N channels, a step-pulse width and a sweep-complete handshake.

## Interface
- `NUM_FREQ_STEPS`, default 32: steps per sweep, must be ≥ 2.
- `STEP_W`, default 8: width of the step index; `NUM_FREQ_STEPS` ≤ 2^`STEP_W`.
- `NUM_CHAN`, default 2: number of RX capture channels.
- `CNT_W`, default 16: tick counter width; all tick values < 2^`CNT_W`.
- `RECORD_TICKS`, default 35000: record window length in cycles.
- `SETTLE_TICKS`, default 256: settle interval after a step, in cycles.
- `STEP_PULSE_TICKS`, default 4: high time of `freq_step_out`, in cycles.
- `ADDR_CFG`, default 7'd66 (`FR_USER_2`): serial address of the configuration register.
- `clock` in 1: `clk64`.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: level; sweeps run only while high.
- `freq_step_reset_in` in 1: debounced, synchronous pulse that restarts the sweep at step 0.
- `chan_mask` in `NUM_CHAN`: per-channel record enable.
- `serial_strobe` in 1, `serial_addr` in 7, `serial_data` in 32: settings bus.
- `freq_step_out` out 1: synthesizer step pulse.
- `freq_step_idx` out `STEP_W`: current step index.
- `rx_reset` out 1: one-cycle capture reset at sweep start.
- `rx_next` out 1: one-cycle pulse at the end of each record window.
- `rx_record` out `NUM_CHAN`: record gate per channel.
- `sweep_done` out 1: one-cycle pulse coinciding with the last `rx_next`.
- `state_out` out 3: FSM state, for debug.

## Operation
- All outputs are registered. On `reset`: state IDLE, every output 0, tick counter 0.
- States: IDLE, RXRST, SETTLE, RECORD, NEXT, STEP, WAITSYNC.
- IDLE: when `enable` is high, go to RXRST.
- RXRST: `rx_reset`=1 and `freq_step_idx`=0 for one cycle, then go to SETTLE.
- SETTLE: last for `settle_ticks` cycles, then go to RECORD.
- RECORD: `rx_record` = `chan_mask` for `record_ticks` cycles. `chan_mask` is sampled on RECORD entry and held for the window.
- NEXT: `rx_next`=1 for one cycle.
  - If `freq_step_idx` = `NUM_FREQ_STEPS`-1: `sweep_done`=1 and go to WAITSYNC.
  - Otherwise go to STEP.
- STEP: `freq_step_out`=1 for `STEP_PULSE_TICKS` cycles. `freq_step_idx` increments on STEP entry. Then go to SETTLE.
- WAITSYNC: hold `freq_step_idx` at the last step. On `freq_step_reset_in`, go to RXRST.
- `freq_step_reset_in` in any non-IDLE state aborts to RXRST the next cycle, with `rx_record` and `freq_step_out` dropped immediately.
- `enable` low in any state goes to IDLE the next cycle with all outputs cleared. This takes priority over a simultaneous `freq_step_reset_in`.
- Tick counter: loaded with ticks-1 on state entry, transition fires at 0. A tick value of 0 is treated as 1.

## Timing
- Latency from `enable` sampled high to `rx_reset` high: 1 cycle.
- First step period: 1 (RXRST) + settle + record + 1 (NEXT).
- Each later step: `STEP_PULSE_TICKS` + settle + record + 1.
- `rx_next` and `rx_record` never overlap. `rx_record` falls in the same cycle `rx_next` rises.

## Configuration
- `FAST_SQUARE_SERIAL_CFG_EN` defined:
  - A serial write to `ADDR_CFG` loads `record_ticks` = `serial_data[15:0]` and `settle_ticks` = `serial_data[31:16]`.
  - Reset values are `RECORD_TICKS` and `SETTLE_TICKS`.
  - Values are latched on entry to SETTLE or RECORD, so a write during a window takes effect from the next window.
- Undefined: the tick values are the parameters and the serial ports are unused.

## Structure
- Package `fast_square_pkg`: state encoding constants, default tick constants, `ADDR_CFG` default.
- Sub-module `fs_tick_timer`: loadable down-counter of width `CNT_W` with a zero flag, and zero-to-one clamping.
- Config register reuses `setting_reg`.

## Test plan
Bench uses `NUM_FREQ_STEPS`=4, `RECORD_TICKS`=10, `SETTLE_TICKS`=3, `STEP_PULSE_TICKS`=2, `NUM_CHAN`=2.
- Reset, then `enable`=1 at cycle 0, `chan_mask`=2'b11 → `rx_reset` at cycle 1; `rx_record`=2'b11 for cycles 5–14; `rx_next` at cycle 15; `freq_step_out` at cycles 16–17 with `freq_step_idx`=1.
- Full sweep → exactly 4 `rx_next` and 3 `freq_step_out` pulses; `sweep_done` coincides with the 4th `rx_next` (cycle 63); FSM holds in WAITSYNC with `freq_step_idx`=3.
- `freq_step_reset_in` pulsed during RECORD of step 2 → `rx_record`=0 the next cycle, `rx_reset`=1, `freq_step_idx`=0.
- `enable` low together with `freq_step_reset_in` mid-SETTLE → IDLE, all outputs 0, no `rx_reset`.
- `chan_mask`=2'b01 → `rx_record`=2'b01; a change to 2'b10 mid-window has no effect until the next window.
- With the macro defined: write 32'h0005_0014 to address 66 during RECORD → the current window stays 10 cycles, the next settle is 5 cycles and the next record is 20. A write of 32'h0 gives 1-cycle windows.
